// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the DRAM request arbiter: FSM states, operation codes
// and the timeout counter width.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RECOVER = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  localparam int TMO_CNT_W = 8;

  // A single-port index still needs one bit so the vectors stay legal.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index after
// the last-granted pointer, wrapping at N.
module rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [IDXW-1:0] o_grant,
  output logic            o_any
);

  logic [IDXW-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = IDXW'((int'(i_last) + k) % N);
      if (i_req[w_cand]) begin
        o_grant = w_cand;
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port among NPORTS
// requesters, with latched requests, routed completion strobes and a hang timeout.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        p_req_read,
  input  logic [NPORTS-1:0]        p_req_write,
  input  logic [NPORTS*ADDR_W-1:0] p_addr,
  input  logic [NPORTS*DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0]        p_rdata,
  output logic [NPORTS-1:0]        p_data_valid,
  output logic [NPORTS-1:0]        p_write_complete,
  output logic                     m_req_read,
  output logic                     m_req_write,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_data_valid,
  input  logic                     m_write_complete,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IDXW = idx_width(NPORTS);

  arb_state_t            r_state, r_state_next;
  arb_op_t               r_op, r_op_next;
  logic [IDXW-1:0]       r_rr, r_rr_next;
  logic [IDXW-1:0]       r_port, r_port_next;
  logic [ADDR_W-1:0]     r_addr, r_addr_next;
  logic [DATA_W-1:0]     r_wdata, r_wdata_next;
  logic [DATA_W-1:0]     r_rdata, r_rdata_next;
  logic [NPORTS-1:0]     r_dv, r_dv_next;
  logic [NPORTS-1:0]     r_wc, r_wc_next;
  logic                  r_mrd, r_mrd_next;
  logic                  r_mwr, r_mwr_next;
  logic                  r_busy, r_busy_next;
  logic                  r_tmo_err, r_tmo_err_next;
  logic [TMO_CNT_W-1:0]  r_tmo_cnt, r_tmo_cnt_next;

  logic [NPORTS-1:0]     w_req;
  logic [IDXW-1:0]       w_pick;
  logic                  w_any;
  logic                  w_done;
  logic                  w_expired;
  logic [ADDR_W-1:0]     w_addr_arr  [NPORTS];
  logic [DATA_W-1:0]     w_wdata_arr [NPORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_unpack
      assign w_addr_arr[gi]  = p_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata_arr[gi] = p_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_req = p_req_read | p_req_write;

  rr_pick #(
    .N    (NPORTS),
    .IDXW (IDXW)
  ) u_pick (
    .i_req   (w_req),
    .i_last  (r_rr),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  assign w_done    = (r_op == OP_WR) ? m_write_complete : m_data_valid;
  assign w_expired = (r_tmo_cnt == TMO_CNT_W'(TIMEOUT - 1));

  always_comb begin
    r_state_next   = r_state;
    r_op_next      = r_op;
    r_rr_next      = r_rr;
    r_port_next    = r_port;
    r_addr_next    = r_addr;
    r_wdata_next   = r_wdata;
    r_rdata_next   = r_rdata;
    r_dv_next      = '0;
    r_wc_next      = '0;
    r_mrd_next     = r_mrd;
    r_mwr_next     = r_mwr;
    r_tmo_err_next = r_tmo_err;
    r_tmo_cnt_next = r_tmo_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          // Write wins when a port raises both; its read stays pending.
          r_port_next    = w_pick;
          r_rr_next      = w_pick;
          r_op_next      = p_req_write[w_pick] ? OP_WR : OP_RD;
          r_addr_next    = w_addr_arr[w_pick];
          r_wdata_next   = w_wdata_arr[w_pick];
          r_mwr_next     = p_req_write[w_pick];
          r_mrd_next     = !p_req_write[w_pick];
          r_tmo_cnt_next = '0;
          r_state_next   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_done || w_expired) begin
          r_mrd_next   = 1'b0;
          r_mwr_next   = 1'b0;
          r_rdata_next = w_done ? m_rdata : '0;
          r_state_next = ST_RECOVER;
          if (!w_done) r_tmo_err_next = 1'b1;
          if (r_op == OP_WR) r_wc_next[r_port] = 1'b1;
          else               r_dv_next[r_port] = 1'b1;
        end else begin
          r_tmo_cnt_next = r_tmo_cnt + 1'b1;
        end
      end
      ST_RECOVER: r_state_next = ST_IDLE;
      default:    r_state_next = ST_IDLE;
    endcase
    r_busy_next = (r_state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_RD;
      r_rr      <= IDXW'(NPORTS - 1);
      r_port    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_dv      <= '0;
      r_wc      <= '0;
      r_mrd     <= 1'b0;
      r_mwr     <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= r_state_next;
      r_op      <= r_op_next;
      r_rr      <= r_rr_next;
      r_port    <= r_port_next;
      r_addr    <= r_addr_next;
      r_wdata   <= r_wdata_next;
      r_rdata   <= r_rdata_next;
      r_dv      <= r_dv_next;
      r_wc      <= r_wc_next;
      r_mrd     <= r_mrd_next;
      r_mwr     <= r_mwr_next;
      r_busy    <= r_busy_next;
      r_tmo_err <= r_tmo_err_next;
      r_tmo_cnt <= r_tmo_cnt_next;
    end
  end

  assign p_rdata          = r_rdata;
  assign p_data_valid     = r_dv;
  assign p_write_complete = r_wc;
  assign m_req_read       = r_mrd;
  assign m_req_write      = r_mwr;
  assign m_addr           = r_addr;
  assign m_wdata          = r_wdata;
  assign busy             = r_busy;
  assign timeout_err      = r_tmo_err;

endmodule

// File: tb/tb_dram_arbiter.sv
// Randomized scoreboard bench for dram_arbiter: requester engine, controller
// model with random latency/noise, and a monitor checking grants and strobes.
`timescale 1ns/1ps
module tb_dram_arbiter;

  localparam int NP   = 2;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int TMO  = 255;
  localparam int HANG = 100000;

  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0]    p_req_read, p_req_write, p_data_valid, p_write_complete;
  logic [NP*AW-1:0] p_addr;
  logic [NP*DW-1:0] p_wdata;
  logic [DW-1:0]    p_rdata, m_wdata, m_rdata;
  logic [AW-1:0]    m_addr;
  logic m_req_read, m_req_write, m_data_valid, m_write_complete, busy, timeout_err;

  always #5 clk = ~clk;

  dram_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_req_read(p_req_read), .p_req_write(p_req_write),
    .p_addr(p_addr), .p_wdata(p_wdata), .p_rdata(p_rdata),
    .p_data_valid(p_data_valid), .p_write_complete(p_write_complete),
    .m_req_read(m_req_read), .m_req_write(m_req_write),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_data_valid(m_data_valid), .m_write_complete(m_write_complete),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Per-port requester drive and observation copies
  logic          rd_arr [NP];
  logic          wr_arr [NP];
  logic [AW-1:0] addr_arr [NP];
  logic [DW-1:0] wdata_arr [NP];
  logic          dv_arr [NP];
  logic          wc_arr [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      assign p_req_read[gi]         = rd_arr[gi];
      assign p_req_write[gi]        = wr_arr[gi];
      assign p_addr[gi*AW +: AW]    = addr_arr[gi];
      assign p_wdata[gi*DW +: DW]   = wdata_arr[gi];
      assign dv_arr[gi]             = p_data_valid[gi];
      assign wc_arr[gi]             = p_write_complete[gi];
    end
  endgenerate

  typedef struct { int port; bit wr; logic [DW-1:0] data; } exp_t;
  typedef struct { int port; int kind; logic [AW-1:0] addr; logic [DW-1:0] wdata; bit hang; } op_t;

  exp_t exp_q[$];
  op_t  ops[$];
  int   grant_log[$];
  logic [DW-1:0] shadow  [logic [AW-1:0]];
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];

  int total = 0;
  int bad = 0;
  int ctl_delay = 0;
  bit ctl_noise = 0;
  bit inject_wc = 0;
  int last_run = 0;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hA5C3, a[23:16], 8'h3C};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference arbitration rule: first requesting port after the last grant.
  function automatic int rr_ref(input int last);
    for (int k = 1; k <= NP; k++) begin
      int q;
      q = (last + k) % NP;
      if (rd_arr[q] || wr_arr[q]) return q;
    end
    return -1;
  endfunction

  // ---------------- controller model ----------------
  bit srv = 0;
  bit srv_wr;
  logic [AW-1:0] srv_addr;
  logic [DW-1:0] srv_data;
  int srv_cnt, srv_dly;

  always @(negedge clk) begin
    if (!rst_n) begin
      srv = 0; m_data_valid = 0; m_write_complete = 0;
    end else begin
      m_data_valid = 0; m_write_complete = 0; m_rdata = $urandom;
      if (inject_wc) begin m_write_complete = 1; inject_wc = 0; end
      if (m_req_read || m_req_write) begin
        if (!srv) begin
          srv = 1; srv_wr = m_req_write; srv_addr = m_addr; srv_data = m_wdata; srv_cnt = 0;
          srv_dly = (ctl_delay > 0) ? ctl_delay : int'($urandom_range(1, 8));
        end else begin
          chk("m_addr_stable", m_addr, srv_addr);
          chk("m_op_stable", m_req_write, srv_wr);
          if (srv_wr) chk("m_wdata_stable", m_wdata, srv_data);
        end
        srv_cnt++;
        if (srv_cnt == srv_dly) begin
          if (srv_wr) begin ctl_mem[srv_addr] = srv_data; m_write_complete = 1; end
          else begin
            m_rdata = ctl_mem.exists(srv_addr) ? ctl_mem[srv_addr] : dflt(srv_addr);
            m_data_valid = 1;
          end
          srv = 0;
        end else if (ctl_noise && $urandom_range(0, 3) == 0) begin
          if (srv_wr) m_data_valid = 1; else m_write_complete = 1;
        end
      end else begin
        srv = 0;
        if (ctl_noise && $urandom_range(0, 7) == 0) begin m_data_valid = 1; m_write_complete = 1; end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit mon_prev = 0;
  bit mon_first = 1;
  int mon_last = NP - 1;
  int low_run = 0;
  int high_run = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mon_prev = 0; mon_first = 1; mon_last = NP - 1; low_run = 0; high_run = 0;
    end else begin
      bit cur;
      for (int p = 0; p < NP; p++) begin
        if (dv_arr[p] || wc_arr[p]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].port == p) idx = i;
          if (idx < 0) begin
            total++; bad++;
            $display("FAIL unexpected_strobe port=%0d actual dv=%0b wc=%0b required none", p, dv_arr[p], wc_arr[p]);
          end else begin
            exp_t e;
            e = exp_q[idx];
            exp_q.delete(idx);
            chk($sformatf("strobe_kind_p%0d", p), wc_arr[p], e.wr);
            if (!e.wr) chk($sformatf("rdata_p%0d", p), p_rdata, e.data);
          end
        end
      end
      chk("m_req_exclusive", m_req_read & m_req_write, 0);
      cur = m_req_read | m_req_write;
      if (cur && !mon_prev) begin
        int ep, ap;
        ep = rr_ref(mon_last);
        ap = -1;
        for (int q = 0; q < NP; q++)
          if (ap < 0 && addr_arr[q] == m_addr && (rd_arr[q] || wr_arr[q])) ap = q;
        if (ep >= 0 && ap != ep && addr_arr[ep] == m_addr) ap = ep;
        chk("grant_port", ap, ep);
        if (ep >= 0) begin
          chk("grant_op_write", m_req_write, wr_arr[ep]);
          if (wr_arr[ep]) chk("grant_wdata", m_wdata, wdata_arr[ep]);
          mon_last = ep;
        end
        if (!mon_first) chk("mreq_gap_ge2", low_run >= 2, 1);
        grant_log.push_back(ap);
        mon_first = 0;
        high_run = 0;
      end
      if (cur) high_run++;
      if (!cur && mon_prev) begin last_run = high_run; low_run = 0; end
      if (!cur) low_run++;
      mon_prev = cur;
    end
  end

  // ---------------- requester engine ----------------
  function automatic bit has_op(input int p);
    foreach (ops[i]) if (ops[i].port == p) return 1;
    return 0;
  endfunction

  task automatic add_op(input int p, input int kind, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hang);
    op_t o;
    o.port = p; o.kind = kind; o.addr = a; o.wdata = d; o.hang = hang;
    ops.push_back(o);
  endtask

  task automatic issue(input int p);
    int idx;
    op_t o;
    exp_t e;
    idx = 0;
    for (int i = ops.size() - 1; i >= 0; i--) if (ops[i].port == p) idx = i;
    o = ops[idx];
    ops.delete(idx);
    addr_arr[p] = o.addr;
    wdata_arr[p] = o.wdata;
    e.port = p;
    if (o.kind != 0) begin
      shadow[o.addr] = o.wdata;
      e.wr = 1; e.data = '0;
      exp_q.push_back(e);
      wr_arr[p] = 1;
    end
    if (o.kind != 1) begin
      e.wr = 0;
      e.data = o.hang ? '0 : (shadow.exists(o.addr) ? shadow[o.addr] : dflt(o.addr));
      exp_q.push_back(e);
      rd_arr[p] = 1;
    end
  endtask

  task automatic run_engine(input int max_gap, input string tag);
    bit act [NP];
    int gap [NP];
    int cyc;
    bit more;
    cyc = 0;
    for (int p = 0; p < NP; p++) begin act[p] = 0; gap[p] = 0; end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (act[p]) begin
          if (wc_arr[p]) wr_arr[p] = 0;
          if (dv_arr[p]) rd_arr[p] = 0;
          if (!rd_arr[p] && !wr_arr[p]) begin
            act[p] = 0;
            gap[p] = $urandom_range(0, max_gap);
          end
        end
        if (!act[p] && has_op(p)) begin
          if (gap[p] == 0) begin issue(p); act[p] = 1; end
          else gap[p]--;
        end
      end
      more = 0;
      for (int p = 0; p < NP; p++) if (act[p] || has_op(p)) more = 1;
      if (!more) break;
      cyc++;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL engine_bound %s actual=%0d cycles required<=20000", tag, cyc);
        ops.delete();
        for (int p = 0; p < NP; p++) begin rd_arr[p] = 0; wr_arr[p] = 0; end
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    rst_n = 0;
    m_rdata = '0; m_data_valid = 0; m_write_complete = 0;
    for (int p = 0; p < NP; p++) begin
      rd_arr[p] = 0; wr_arr[p] = 0; addr_arr[p] = '0; wdata_arr[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_m_req_read", m_req_read, 0);
    chk("rst_m_req_write", m_req_write, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_p_data_valid", p_data_valid, 0);
    chk("rst_p_write_complete", p_write_complete, 0);
    @(negedge clk);
    rst_n = 1;

    // Contention right after reset: port 0 must win first
    ctl_delay = 3;
    grant_log.delete();
    add_op(0, 1, 24'h000100, 32'h12345678, 0);
    add_op(1, 0, 24'h000200, '0, 0);
    run_engine(0, "contention");
    if (grant_log.size() < 2) begin
      total++; bad++;
      $display("FAIL contention_grants actual=%0d grants required=2", grant_log.size());
    end else begin
      chk("contention_first", grant_log[0], 0);
      chk("contention_second", grant_log[1], 1);
    end
    chk("contention_mem", ctl_mem.exists(24'h000100) ? ctl_mem[24'h000100] : '0, 32'h12345678);

    // Fairness: both ports continuously requesting
    grant_log.delete();
    for (int i = 0; i < 4; i++)
      for (int p = 0; p < NP; p++)
        add_op(p, int'($urandom_range(0, 1)), {2'(p), 18'b0, 4'($urandom_range(0, 15))}, $urandom, 0);
    ctl_delay = 0;
    run_engine(0, "fairness");
    chk("fairness_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk($sformatf("fairness_grant%0d", i), grant_log[i], i % 2);

    // Single port read with a 6-cycle controller latency
    ctl_delay = 6;
    ctl_mem[24'h000010] = 32'hDEADBEEF;
    shadow[24'h000010]  = 32'hDEADBEEF;
    add_op(0, 0, 24'h000010, '0, 0);
    run_engine(0, "single");
    chk("single_mreq_cycles", last_run, 6);
    chk("single_rdata_held", p_rdata, 32'hDEADBEEF);

    // Random traffic with controller noise and mixed ops
    ctl_delay = 0;
    ctl_noise = 1;
    for (int i = 0; i < 40; i++) begin
      int p;
      p = $urandom_range(0, NP - 1);
      add_op(p, int'($urandom_range(0, 2)), {2'(p), 18'b0, 4'($urandom_range(0, 15))}, $urandom, 0);
    end
    run_engine(3, "random");
    ctl_noise = 0;

    // Controller hang on a port 1 read
    chk("tmo_err_before", timeout_err, 0);
    ctl_delay = HANG;
    add_op(1, 0, 24'h400020, '0, 1);
    run_engine(0, "timeout");
    chk("tmo_mreq_cycles", last_run, TMO);
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_rdata_zero", p_rdata, 0);
    ctl_delay = 3;
    add_op(0, 1, 24'h000030, 32'hCAFEF00D, 0);
    run_engine(0, "after_timeout");
    chk("tmo_err_sticky", timeout_err, 1);

    // Reset in the middle of a port 0 write
    ctl_delay = HANG;
    @(negedge clk);
    addr_arr[0] = 24'h000300; wdata_arr[0] = 32'hA5A5A5A5; wr_arr[0] = 1;
    waited = 0;
    while (!m_req_write && waited < 20) begin @(negedge clk); waited++; end
    chk("midrst_granted", m_req_write, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_outputs_zero",
        {busy, timeout_err, m_req_read, m_req_write, |m_addr, |m_wdata, |p_rdata,
         |p_data_valid, |p_write_complete}, 0);
    wr_arr[0] = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    inject_wc = 1;
    repeat (4) @(negedge clk);
    chk("midrst_late_wc_idle", busy, 0);
    chk("midrst_tmo_cleared", timeout_err, 0);
    ctl_delay = 2;
    add_op(1, 0, 24'h400040, '0, 0);
    run_engine(0, "post_reset");
    chk("post_reset_mreq_cycles", last_run, 2);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
